// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers pixel coordinates, qualifies the visible
// region, tracks lock against the configured timing and counts sync violations.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pixel_valid,
  output logic [2:0] pixel_rgb,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_error,
  output logic [7:0] error_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Counters are 10 bits wide; totals above 1024 cannot be represented.
  localparam logic [9:0] HsStart    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HsEnd      = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VsLine     = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [7:0] LockFrames = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {StUnlocked, StSyncing, StLocked} state_e;

  // Input stage and edge-detect history
  logic       hs_r_q, vs_r_q, hs_rr_q, vs_rr_q;
  logic [2:0] rgb_r_q;
  logic       hs_rise, hs_fall, vs_rise;

  // Coordinate tracking
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0] cur_h, cur_v;
  logic       viol;

  // Lock FSM
  state_e     state_q, state_d;
  logic [7:0] good_frames_q, good_frames_d;
  logic       frame_clean_q, frame_clean_d;

  // Registered outputs
  logic [9:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic       pixel_valid_q, pixel_valid_d;
  logic [2:0] pixel_rgb_q, pixel_rgb_d;
  logic       locked_q, locked_d;
  logic       frame_start_q, frame_start_d;
  logic       sync_error_q, sync_error_d;
  logic [7:0] error_count_q, error_count_d;

  // Capture pins once, keep one more stage for edge detection, advance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r_q  <= 1'b0;
      vs_r_q  <= 1'b0;
      hs_rr_q <= 1'b0;
      vs_rr_q <= 1'b0;
      rgb_r_q <= 3'd0;
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      hs_r_q  <= hsync;
      vs_r_q  <= vsync;
      hs_rr_q <= hs_r_q;
      vs_rr_q <= vs_r_q;
      rgb_r_q <= rgb;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Edge detection, alignment of the current sample's coordinate, next coordinate
  always_comb begin
    hs_rise = hs_r_q & ~hs_rr_q;
    hs_fall = ~hs_r_q & hs_rr_q;
    vs_rise = vs_r_q & ~vs_rr_q;

    // hsync owns the column when both edges coincide; vsync still owns the row
    cur_h = h_cnt_q;
    if (hs_rise) begin
      cur_h = HsStart;
    end else if (vs_rise) begin
      cur_h = 10'd0;
    end
    cur_v = vs_rise ? VsLine : v_cnt_q;

    h_cnt_d = (cur_h == HLast) ? 10'd0 : cur_h + 10'd1;
    v_cnt_d = cur_v;
    if (cur_h == HLast) begin
      v_cnt_d = (cur_v == VLast) ? 10'd0 : cur_v + 10'd1;
    end

    // Checks use the free-running counters, before any realignment
    viol = (hs_rise && (h_cnt_q != HsStart))
        || ((h_cnt_q == HsStart) && !hs_rise)
        || (hs_fall && (h_cnt_q != HsEnd))
        || (vs_rise && ((h_cnt_q != 10'd0) || (v_cnt_q != VsLine)))
        || ((h_cnt_q == 10'd0) && (v_cnt_q == VsLine) && !vs_rise);
  end

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StUnlocked;
      good_frames_q <= 8'd0;
      frame_clean_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_frames_q <= good_frames_d;
      frame_clean_q <= frame_clean_d;
    end
  end

  // Lock FSM next state; a violation on a vsync rise starts the new frame clean
  always_comb begin
    state_d       = state_q;
    good_frames_d = good_frames_q;
    frame_clean_d = frame_clean_q;
    unique case (state_q)
      StUnlocked: begin
        if (vs_rise) begin
          state_d       = StSyncing;
          good_frames_d = 8'd0;
          frame_clean_d = 1'b1;
        end
      end
      StSyncing: begin
        if (viol) begin
          good_frames_d = 8'd0;
          frame_clean_d = vs_rise;
        end else if (vs_rise) begin
          frame_clean_d = 1'b1;
          if (frame_clean_q) begin
            good_frames_d = good_frames_q + 8'd1;
            if (good_frames_d >= LockFrames) begin
              state_d = StLocked;
            end
          end
        end
      end
      StLocked: begin
        if (viol) begin
          state_d       = StSyncing;
          good_frames_d = 8'd0;
          frame_clean_d = vs_rise;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Output values for the current sample; lock follows the state being entered
  always_comb begin
    locked_d      = (state_d == StLocked);
    sync_error_d  = (state_q == StLocked) && viol;
    x_pos_d       = cur_h;
    y_pos_d       = cur_v;
    pixel_valid_d = locked_d && (cur_h < HVis) && (cur_v < VVis);
    pixel_rgb_d   = pixel_valid_d ? rgb_r_q : 3'd0;
    frame_start_d = locked_d && (cur_h == 10'd0) && (cur_v == 10'd0);
    error_count_d = error_count_q;
    if (sync_error_d && (error_count_q != 8'hFF)) begin
      error_count_d = error_count_q + 8'd1;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos_q       <= 10'd0;
      y_pos_q       <= 10'd0;
      pixel_valid_q <= 1'b0;
      pixel_rgb_q   <= 3'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_error_q  <= 1'b0;
      error_count_q <= 8'd0;
    end else begin
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_rgb_q   <= pixel_rgb_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      sync_error_q  <= sync_error_d;
      error_count_q <= error_count_d;
    end
  end

  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_error  = sync_error_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down 10x6 raster so whole frames are cheap.
module tb_vga_sync_decoder;

  localparam int HV = 5, HF = 1, HS = 2, HB = 2;
  localparam int VV = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;  // 10
  localparam int VT = VV + VF + VS + VB;  // 6
  localparam int HSS = HV + HF;           // hsync high for columns 6..7
  localparam int HSE = HSS + HS;
  localparam int VSL = VV + VF;           // vsync high on line 4

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync = 1'b0, vsync = 1'b0;
  logic [2:0] rgb = 3'd0;
  logic [9:0] x_pos, y_pos;
  logic       pixel_valid, locked, frame_start, sync_error;
  logic [2:0] pixel_rgb;
  logic [7:0] error_count;

  int tests = 0, fails = 0;
  int gh = 3, gv = 2;          // generator coordinate currently on the pins
  int cur_mode = 0;            // 0 nominal, 1 hsync delayed by one, 2 hsync held low
  int hmode = 0, hmode_lines = 0;
  bit vs_force = 1'b0;
  int se_pulses = 0;

  typedef struct {
    int gh; int gv; int ex; int ey; int ev; int ergb; int efs;
  } vec_t;
  vec_t vecs[10];

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x_pos(x_pos), .y_pos(y_pos), .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb),
    .locked(locked), .frame_start(frame_start), .sync_error(sync_error),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (gen %0d,%0d)", name, act, exp, gh, gv);
    end
  endtask

  function automatic void drive();
    if (cur_mode == 2) hsync = 1'b0;
    else if (cur_mode == 1) hsync = (gh >= HSS + 1) && (gh < HSE + 1);
    else hsync = (gh >= HSS) && (gh < HSE);
    vsync = ((gv >= VSL) && (gv < VSL + VS)) || vs_force;
    vs_force = 1'b0;
    rgb = 3'((gh + 2 * gv) % 8);
  endfunction

  // One clock: observe outputs of this edge, then advance the generator
  task automatic tick();
    @(posedge clk);
    #1;
    if (sync_error === 1'b1) se_pulses++;
    if (gh == HT - 1) begin
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
    if (gh == 0) begin
      if (hmode_lines > 0) begin
        cur_mode = hmode;
        hmode_lines--;
      end else begin
        cur_mode = 0;
      end
    end
    drive();
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(gh == h && gv == v) && n < 200) begin
      tick();
      n++;
    end
    check("reach_position", 32'(gh * 100 + gv), 32'(h * 100 + v));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x_pos"}, 32'(x_pos), 0);
    check({tag, "_y_pos"}, 32'(y_pos), 0);
    check({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    check({tag, "_pixel_rgb"}, 32'(pixel_rgb), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_sync_error"}, 32'(sync_error), 0);
    check({tag, "_error_count"}, 32'(error_count), 0);
  endtask

  // Lock appears two cycles after the third vsync rise sample, never earlier
  task automatic check_relock(input string tag);
    for (int r = 1; r <= 3; r++) begin
      run_to(1, VSL);
      check({tag, "_locked_before_rise"}, 32'(locked), 0);
      run_to(2, VSL);
      check({tag, "_locked_after_rise"}, 32'(locked), (r == 3) ? 1 : 0);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int nvalid, nfs, nlag, se0, ex, ey, erg;
    bit stuck;

    vecs[0] = '{0, 0, 8, 5, 0, 0, 0};
    vecs[1] = '{1, 0, 9, 5, 0, 0, 0};
    vecs[2] = '{2, 0, 0, 0, 1, 0, 1};
    vecs[3] = '{3, 0, 1, 0, 1, 1, 0};
    vecs[4] = '{6, 1, 4, 1, 1, 6, 0};
    vecs[5] = '{7, 1, 5, 1, 0, 0, 0};
    vecs[6] = '{5, 2, 3, 2, 1, 7, 0};
    vecs[7] = '{1, 3, 9, 2, 0, 0, 0};
    vecs[8] = '{2, 3, 0, 3, 0, 0, 0};
    vecs[9] = '{2, 4, 0, 4, 0, 0, 0};

    // Reset held for three cycles with random pins
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      rgb = 3'($urandom);
    end
    check_zero("reset");
    rst = 1'b0;
    drive();

    // Acquire lock from a mid-frame start
    check_relock("lock");

    // Coordinates and qualifiers across one locked frame
    for (int i = 0; i < 10; i++) begin
      run_to(vecs[i].gh, vecs[i].gv);
      check($sformatf("vector_%0d", i),
            32'({x_pos, y_pos, pixel_valid, pixel_rgb, frame_start}),
            32'({10'(vecs[i].ex), 10'(vecs[i].ey), 1'(vecs[i].ev), 3'(vecs[i].ergb),
                 1'(vecs[i].efs)}));
    end

    // Full-frame statistics and two-cycle lag against the generator
    nvalid = 0; nfs = 0; nlag = 0;
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      ex = gh - 2; ey = gv;
      if (ex < 0) begin
        ex += HT;
        ey = (ey == 0) ? VT - 1 : ey - 1;
      end
      erg = (ex < HV && ey < VV) ? (ex + 2 * ey) % 8 : 0;
      if (x_pos !== 10'(ex) || y_pos !== 10'(ey) || pixel_rgb !== 3'(erg)) nlag++;
      if (pixel_valid === 1'b1) nvalid++;
      if (frame_start === 1'b1) nfs++;
    end
    check("frame_lag_mismatches", 32'(nlag), 0);
    check("frame_valid_count", 32'(nvalid), 32'(HV * VV));
    check("frame_start_count", 32'(nfs), 1);
    check("nominal_error_count", 32'(error_count), 0);

    // Delay one hsync pulse by a cycle on line 1
    run_to(HT - 1, 0);
    hmode = 1; hmode_lines = 1;
    se0 = se_pulses;
    run_to(HSS + 1, 1);
    check("shift_no_early_error", 32'({sync_error, locked}), 32'(2'b01));
    run_to(HSS + 2, 1);
    check("shift_error_pulse", 32'({sync_error, locked}), 32'(2'b10));
    check("shift_error_count", 32'(error_count), 1);
    check_relock("shift");
    check("shift_single_pulse", 32'(se_pulses - se0), 1);
    check("shift_error_count_final", 32'(error_count), 1);

    // Reset mid-frame while locked
    run_to(3, 1);
    pulse_reset();
    check_zero("midreset");
    check_relock("midreset");

    // hsync held low for three lines
    run_to(HT - 1, 0);
    hmode = 2; hmode_lines = 3;
    se0 = se_pulses;
    run_to(HSS + 2, 1);
    check("missing_error_pulse", 32'({sync_error, locked}), 32'(2'b10));
    check_relock("missing");
    check("missing_single_pulse", 32'(se_pulses - se0), 1);
    check("missing_error_count", 32'(error_count), 1);

    // One-cycle vsync glitch at (3,2)
    pulse_reset();
    check_relock("pre_glitch");
    run_to(2, 2);
    vs_force = 1'b1;
    se0 = se_pulses;
    run_to(4, 2);
    check("glitch_no_early_error", 32'({sync_error, locked}), 32'(2'b01));
    run_to(5, 2);
    check("glitch_error_pulse", 32'({sync_error, locked}), 32'(2'b10));
    check_relock("glitch");
    check("glitch_single_pulse", 32'(se_pulses - se0), 1);
    check("glitch_error_count", 32'(error_count), 1);

    // Saturation: 260 violations, each one from a fresh lock
    pulse_reset();
    check_relock("pre_sat");
    se0 = se_pulses;
    stuck = 1'b0;
    for (int i = 0; i < 260 && !stuck; i++) begin
      int n;
      hmode = 2; hmode_lines = 1;
      n = 0;
      while (locked !== 1'b0 && n < 60) begin tick(); n++; end
      if (locked !== 1'b0) stuck = 1'b1;
      n = 0;
      while (locked !== 1'b1 && n < 400) begin tick(); n++; end
      if (locked !== 1'b1) stuck = 1'b1;
      if (i == 253) check("sat_count_254", 32'(error_count), 254);
    end
    check("sat_lock_cycles_completed", 32'(stuck), 0);
    check("sat_pulses", 32'(se_pulses - se0), 260);
    check("sat_error_count", 32'(error_count), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
